i2c_slave_rx: RTL

- Write-only I2C target (responder) for the other end of our I2C master write FSM.
- Oversamples the SCL and SDA inputs on the system clock and detects START, repeated START and STOP.
- Matches the 7-bit address against `own_addr` and ACKs the address and each accepted data byte by pulling SDA low (open-drain).
- Delivers each received byte on an AXI-Stream master port.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_line_sync.sv | 52 +++++
 rtl/i2c_slave_rx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receive path.
package i2c_pkg;

  localparam int   I2C_ADDR_WIDTH = 7;
  localparam int   I2C_BYTE_WIDTH = 8;
  localparam logic RW_WRITE       = 1'b0;

  // Protocol states of the write-only target.
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    DATA,
    ACK_DATA,
    NACK_DATA,
    IGNORE
  } i2c_state_e;

  // True when an address byte (7-bit address + R/W) is a write to own_addr.
  function automatic logic is_write_to(input logic [I2C_BYTE_WIDTH-1:0] addr_byte,
                                       input logic [I2C_ADDR_WIDTH-1:0] own_addr);
    return (addr_byte[I2C_BYTE_WIDTH-1:1] == own_addr) && (addr_byte[0] == RW_WRITE);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the asynchronous SCL/SDA pads and derives bus events:
// SCL edges, START (SDA fall with SCL high) and STOP (SDA rise with SCL high).
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic sda_s_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;
  logic                   scl_s;
  logic                   sda_s;

  // Synchronizer chains plus one delayed copy of each line for edge detection.
  // NOTE: these flops reset to 1 (the idle bus level) so reset release
  // never fabricates a START, STOP or SCL edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign sda_s_o    = sda_s;
  // SCL must be high on both samples so an SCL edge coinciding with an SDA
  // change is never mistaken for a bus condition.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: detects START/STOP, matches the 7-bit address,
// ACKs address and accepted data bytes, and streams bytes out over AXIS.
// Only ADDR_WIDTH=7 and DATA_WIDTH=8 are supported; SYNC_STAGES must be >= 2.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter int ADDR_WIDTH  = I2C_ADDR_WIDTH,
  parameter int DATA_WIDTH  = I2C_BYTE_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  input  logic [ADDR_WIDTH-1:0] own_addr,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overflow
);

  logic scl_rise;
  logic scl_fall;
  logic sda_s;
  logic start;
  logic stop;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .arst      (arst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .sda_s_o   (sda_s),
    .start_o   (start),
    .stop_o    (stop)
  );

  i2c_state_e            state_q,     state_d;
  logic [2:0]            cnt_q,       cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic                  byte_done_q, byte_done_d;
  logic                  sda_oe_q,    sda_oe_d;
  logic                  busy_q,      busy_d;
  logic                  tvalid_q,    tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q,     tdata_d;
  logic                  overflow_q,  overflow_d;

  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  can_load;

  // Shift register contents including the bit being sampled this clk.
  assign rx_byte  = {shift_q[DATA_WIDTH-2:0], sda_s};
  // The output register can take a byte if empty or being drained this clk.
  assign can_load = ~tvalid_q | m_axis_tready;

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd7;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      overflow_q  <= overflow_d;
    end
  end

  // Next-state logic: bus conditions first, then per-state bit handling.
  // NOTE: every signal gets a hold/default value up front so no path through
  // the case leaves one unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    byte_done_d = byte_done_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    overflow_d  = 1'b0;

    // Downstream handshake; a load below in the same clk overrides this.
    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    if (start) begin
      state_d     = ADDR;
      cnt_d       = 3'd7;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else if (stop) begin
      state_d     = IDLE;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
        end

        ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (cnt_q == 3'd0) begin
              if (is_write_to(rx_byte, own_addr)) begin
                state_d = ACK_ADDR;
                busy_d  = 1'b1;
              end else begin
                // Mismatch or read request: stay off the bus until the next condition.
                state_d = IGNORE;
              end
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end

        ACK_ADDR: begin
          // First fall opens the ACK slot, second fall closes it.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d    = 1'b0;
              state_d     = DATA;
              cnt_d       = 3'd7;
              byte_done_d = 1'b0;
            end
          end
        end

        DATA: begin
          if (scl_rise && !byte_done_q) begin
            shift_d = rx_byte;
            if (cnt_q == 3'd0) begin
              byte_done_d = 1'b1;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end else if (scl_fall && byte_done_q) begin
            if (can_load) begin
              tdata_d  = shift_q;
              tvalid_d = 1'b1;
              sda_oe_d = 1'b1;
              state_d  = ACK_DATA;
            end else begin
              // Output register still full: NACK and drop the byte.
              overflow_d = 1'b1;
              sda_oe_d   = 1'b0;
              state_d    = NACK_DATA;
            end
          end
        end

        ACK_DATA, NACK_DATA: begin
          if (scl_fall) begin
            sda_oe_d    = 1'b0;
            state_d     = DATA;
            cnt_d       = 3'd7;
            byte_done_d = 1'b0;
          end
        end

        IGNORE: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe        = sda_oe_q;
  assign busy          = busy_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign overflow      = overflow_q;

endmodule
